spi_m_burst_ctrl: RTL

Bus-master sequencer for the atmega_spi_m peripheral. It performs multi-byte SPI transfers with no CPU involvement:
- programs SPCR;
- drives chip select;
- writes SPDR;
- polls SPSR.SPIF;
- reads back SPDR.

TX bytes arrive on a valid/ready stream and RX bytes leave on another. It sits between a host engine (boot loader, flash reader) and the SPI master's register port.

---
 rtl/spi_m_burst_ctrl_pkg.sv | 30 +++
 rtl/spi_m_burst_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_m_burst_ctrl_pkg.sv
// Shared definitions for the SPI master burst sequencer: FSM states and
// atmega SPI register bit positions.
package spi_m_burst_ctrl_pkg;

  // Sequencer states. ST_WRDR is the single SPDR write cycle between LOAD and POLL.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CFG      = 4'd1,
    ST_SS_SETUP = 4'd2,
    ST_LOAD     = 4'd3,
    ST_WRDR     = 4'd4,
    ST_POLL     = 4'd5,
    ST_RDDR     = 4'd6,
    ST_RXWAIT   = 4'd7,
    ST_SS_HOLD  = 4'd8,
    ST_ERR      = 4'd9
  } state_t;

  // SPCR bit positions
  localparam int unsigned SPCR_SPIE = 7;
  localparam int unsigned SPCR_SPE  = 6;
  localparam int unsigned SPCR_MSTR = 4;

  // SPSR bit positions
  localparam int unsigned SPSR_SPIF = 7;

  // Master mode, SPI enabled, interrupt left off: the sequencer polls SPIF.
  localparam logic [7:0] SPCR_DEFAULT = 8'((1 << SPCR_SPE) | (1 << SPCR_MSTR));

endpackage

// File: rtl/spi_m_burst_ctrl.sv
// Bus-master sequencer driving the atmega_spi_m register port for
// multi-byte transfers: SPCR setup, chip select, SPDR write, SPIF poll,
// SPDR read-back. TX/RX bytes move on valid/ready streams.
module spi_m_burst_ctrl
  import spi_m_burst_ctrl_pkg::*;
#(
  parameter int unsigned                  BUS_ADDR_DATA_LEN = 6,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = BUS_ADDR_DATA_LEN'(0),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = BUS_ADDR_DATA_LEN'(1),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = BUS_ADDR_DATA_LEN'(2),
  parameter logic [7:0]                   SPCR_VALUE        = SPCR_DEFAULT,
  parameter int unsigned                  LEN_WIDTH         = 8,
  parameter int unsigned                  SS_SETUP_CYC      = 2,
  parameter int unsigned                  SS_HOLD_CYC       = 2,
  parameter int unsigned                  POLL_TIMEOUT      = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         ss_n,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr,
  output logic                         spi_wr,
  output logic                         spi_rd,
  output logic [7:0]                   spi_wdata,
  input  logic [7:0]                   spi_rdata
);

  localparam int unsigned TMO_W    = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned WAIT_MAX = (SS_SETUP_CYC > SS_HOLD_CYC) ? SS_SETUP_CYC : SS_HOLD_CYC;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t                         r_state;
  logic [LEN_WIDTH-1:0]           r_cnt;
  logic [TMO_W-1:0]               r_tmo;
  logic [WAIT_W-1:0]              r_wait;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_err;
  logic [7:0]                     r_rx_data;
  logic                           r_rx_valid;
  logic                           r_ss_n;
  logic [BUS_ADDR_DATA_LEN-1:0]   r_spi_addr;
  logic                           r_spi_wr;
  logic                           r_spi_rd;
  logic [7:0]                     r_spi_wdata;

  state_t                         w_nxt_state;
  logic [LEN_WIDTH-1:0]           w_nxt_cnt;
  logic [TMO_W-1:0]               w_nxt_tmo;
  logic [WAIT_W-1:0]              w_nxt_wait;
  logic                           w_nxt_busy;
  logic                           w_nxt_done;
  logic                           w_nxt_err;
  logic [7:0]                     w_nxt_rx_data;
  logic                           w_nxt_rx_valid;
  logic                           w_nxt_ss_n;
  logic [BUS_ADDR_DATA_LEN-1:0]   w_nxt_spi_addr;
  logic                           w_nxt_spi_wr;
  logic                           w_nxt_spi_rd;
  logic [7:0]                     w_nxt_spi_wdata;

  // TX byte is taken in the same cycle it is offered while waiting in LOAD.
  assign tx_ready = (r_state == ST_LOAD) && tx_valid;

  // Next-state, counters and next register values for all outputs.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_tmo       = r_tmo;
    w_nxt_wait      = r_wait;
    w_nxt_done      = 1'b0;
    w_nxt_err       = r_err;
    w_nxt_rx_data   = r_rx_data;
    w_nxt_rx_valid  = r_rx_valid;
    w_nxt_spi_wr    = 1'b0;
    w_nxt_spi_rd    = 1'b0;
    w_nxt_spi_addr  = '0;
    w_nxt_spi_wdata = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_cnt = len;
          w_nxt_err = 1'b0;
          if (len == '0) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_state = ST_CFG;
          end
        end
      end
      ST_CFG: begin
        w_nxt_state = ST_SS_SETUP;
        w_nxt_wait  = WAIT_W'(SS_SETUP_CYC - 1);
      end
      ST_SS_SETUP: begin
        if (r_wait == '0) begin
          w_nxt_state = ST_LOAD;
        end else begin
          w_nxt_wait = r_wait - WAIT_W'(1);
        end
      end
      ST_LOAD: begin
        if (tx_valid) begin
          w_nxt_state = ST_WRDR;
        end
      end
      ST_WRDR: begin
        w_nxt_state = ST_POLL;
        w_nxt_tmo   = TMO_W'(POLL_TIMEOUT);
      end
      ST_POLL: begin
        if (spi_rdata[SPSR_SPIF]) begin
          w_nxt_state = ST_RDDR;
        end else if (r_tmo == TMO_W'(1)) begin
          w_nxt_state    = ST_ERR;
          w_nxt_err      = 1'b1;
          w_nxt_done     = 1'b1;
          w_nxt_rx_valid = 1'b0;
        end else begin
          w_nxt_tmo = r_tmo - TMO_W'(1);
        end
      end
      ST_RDDR: begin
        w_nxt_rx_data  = spi_rdata;
        w_nxt_rx_valid = 1'b1;
        w_nxt_state    = ST_RXWAIT;
      end
      ST_RXWAIT: begin
        if (rx_ready) begin
          w_nxt_rx_valid = 1'b0;
          w_nxt_cnt      = r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_nxt_state = ST_SS_HOLD;
            w_nxt_wait  = WAIT_W'(SS_HOLD_CYC - 1);
          end else begin
            w_nxt_state = ST_LOAD;
          end
        end
      end
      ST_SS_HOLD: begin
        if (r_wait == '0) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_wait = r_wait - WAIT_W'(1);
        end
      end
      ST_ERR: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    // Bus strobes are registered so they line up with the state being entered.
    case (w_nxt_state)
      ST_CFG: begin
        w_nxt_spi_wr    = 1'b1;
        w_nxt_spi_addr  = SPCR_ADDR;
        w_nxt_spi_wdata = SPCR_VALUE;
      end
      ST_WRDR: begin
        w_nxt_spi_wr    = 1'b1;
        w_nxt_spi_addr  = SPDR_ADDR;
        w_nxt_spi_wdata = tx_data;
      end
      ST_POLL: begin
        w_nxt_spi_rd   = 1'b1;
        w_nxt_spi_addr = SPSR_ADDR;
      end
      ST_RDDR: begin
        w_nxt_spi_rd   = 1'b1;
        w_nxt_spi_addr = SPDR_ADDR;
      end
      default: ;
    endcase

    w_nxt_ss_n = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_CFG) ||
                 (w_nxt_state == ST_ERR);
    w_nxt_busy = (w_nxt_state != ST_IDLE) && (w_nxt_state != ST_ERR);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_ss_n      <= 1'b1;
      r_spi_addr  <= '0;
      r_spi_wr    <= 1'b0;
      r_spi_rd    <= 1'b0;
      r_spi_wdata <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_tmo       <= w_nxt_tmo;
      r_wait      <= w_nxt_wait;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
      r_err       <= w_nxt_err;
      r_rx_data   <= w_nxt_rx_data;
      r_rx_valid  <= w_nxt_rx_valid;
      r_ss_n      <= w_nxt_ss_n;
      r_spi_addr  <= w_nxt_spi_addr;
      r_spi_wr    <= w_nxt_spi_wr;
      r_spi_rd    <= w_nxt_spi_rd;
      r_spi_wdata <= w_nxt_spi_wdata;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign ss_n      = r_ss_n;
  assign spi_addr  = r_spi_addr;
  assign spi_wr    = r_spi_wr;
  assign spi_rd    = r_spi_rd;
  assign spi_wdata = r_spi_wdata;

endmodule
